// File: rtl/opimm_pkg.sv
// Shared types and the OP-IMM execute function used by the writeback checker
// and anything else that needs a golden RV32I immediate-ALU result.
package opimm_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // imm is already sign-extended; its low five bits double as the shift amount
  function automatic logic [XLEN-1:0] opimm_exec(
    input logic [2:0]      funct3,
    input logic            instr30,
    input logic [XLEN-1:0] src,
    input logic [XLEN-1:0] imm
  );
    logic [XLEN-1:0] res;
    logic [4:0]      shamt;
    shamt = imm[4:0];
    res   = '0;
    case (funct3)
      F3_ADDI:  res = src + imm;
      F3_SLLI:  res = src << shamt;
      F3_SLTI:  res = {{(XLEN-1){1'b0}}, ($signed(src) < $signed(imm))};
      F3_SLTIU: res = {{(XLEN-1){1'b0}}, (src < imm)};
      F3_XORI:  res = src ^ imm;
      F3_SRXI:  res = instr30 ? XLEN'($signed(src) >>> shamt) : (src >> shamt);
      F3_ORI:   res = src | imm;
      F3_ANDI:  res = src & imm;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/opimm_wb_checker_if.sv
// Instruction-stream, preload and register-writeback signals observed by the checker.
interface opimm_wb_checker_if;
  import opimm_pkg::*;

  logic            init_we;
  logic [4:0]      init_addr;
  logic [XLEN-1:0] init_data;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output init_we, init_addr, init_data, instr_valid, instr, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input init_we, init_addr, init_data, instr_valid, instr, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head; pop on empty is ignored and push
// on full is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only pointers and count need a known state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opimm_wb_checker.sv
// Shadows the core's OP-IMM execution and matches the expected writebacks,
// in order, against the core's register-writeback port.
module opimm_wb_checker
  import opimm_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset,
  opimm_wb_checker_if.slave  bus,
  output logic [31:0]        match_count,
  output logic [15:0]        unsupported_count,
  output logic               err_mismatch,
  output logic               err_unexpected,
  output logic               err_overflow,
  output logic               err_timeout,
  output wb_entry_t          first_exp,
  output wb_entry_t          first_act,
  output logic               pass
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [XLEN-1:0] shadow [NUM_REGS];

  logic [4:0]      rd, rs1;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm, src, result;
  logic            push, unsupported;
  wb_entry_t       entry, head, observed;
  logic            full, empty, wb_hit, pop;
  logic            mism, unexp, ovf, tmo;
  logic [TW-1:0]   tcnt, tcnt_next;

  // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
  always_comb begin
    rd          = bus.instr[11:7];
    funct3      = bus.instr[14:12];
    rs1         = bus.instr[19:15];
    imm         = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    src         = (rs1 == '0) ? '0 : shadow[rs1];
    result      = opimm_exec(funct3, bus.instr[30], src, imm);
    push        = bus.instr_valid && (bus.instr[6:0] == OPC_OPIMM) && (rd != '0);
    unsupported = bus.instr_valid && (bus.instr[6:0] != OPC_OPIMM);
    entry       = '{rd: rd, data: result};
    observed    = '{rd: bus.wb_addr, data: bus.wb_data};

    // pop is judged on the pre-push queue state, so a push into an empty queue survives
    wb_hit = bus.wb_valid && (bus.wb_addr != '0);
    pop    = wb_hit && !empty;
    mism   = pop && (observed != head);
    unexp  = wb_hit && empty;
    ovf    = push && full && !pop;

    if (empty || pop)                tcnt_next = '0;
    else if (tcnt == TW'(TIMEOUT))   tcnt_next = tcnt;
    else                             tcnt_next = tcnt + TW'(1);
    tmo = (tcnt_next == TW'(TIMEOUT));
  end

  // Mirrors the core regfile, which has no reset; the instruction commit is
  // written last so it wins over a same-cycle preload to the same register.
  always_ff @(posedge clk) begin
    if (bus.init_we && (bus.init_addr != '0)) shadow[bus.init_addr] <= bus.init_data;
    if (push) shadow[rd] <= result;
  end

  sync_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      match_count       <= '0;
      unsupported_count <= '0;
      err_mismatch      <= 1'b0;
      err_unexpected    <= 1'b0;
      err_overflow      <= 1'b0;
      err_timeout       <= 1'b0;
      first_exp         <= '0;
      first_act         <= '0;
      tcnt              <= '0;
      pass              <= 1'b1;
    end else begin
      tcnt <= tcnt_next;
      if (pop && !mism) match_count <= match_count + 32'd1;
      if (unsupported && (unsupported_count != 16'hFFFF))
        unsupported_count <= unsupported_count + 16'd1;
      if (mism && !err_mismatch) begin
        first_exp <= head;
        first_act <= observed;
      end
      err_mismatch   <= err_mismatch   | mism;
      err_unexpected <= err_unexpected | unexp;
      err_overflow   <= err_overflow   | ovf;
      err_timeout    <= err_timeout    | tmo;
      pass <= !(err_mismatch | mism | err_unexpected | unexp |
                err_overflow | ovf  | err_timeout    | tmo);
    end
  end

endmodule

// File: tb/tb_opimm_wb_checker.sv
// Directed and seeded-random stimulus for opimm_wb_checker; expected status
// snapshots are queued by the driver and compared by an independent monitor.
module tb_opimm_wb_checker;
  import opimm_pkg::*;

  typedef struct packed {
    logic [31:0] mc;
    logic [15:0] uc;
    logic [3:0]  err;   // {mismatch, unexpected, overflow, timeout}
    logic        pass;
    wb_entry_t   fe;
    wb_entry_t   fa;
  } status_t;

  typedef struct {
    string   tag;
    int      at;
    status_t st;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  logic clk, reset;
  logic [31:0] match_count;
  logic [15:0] unsupported_count;
  logic err_mismatch, err_unexpected, err_overflow, err_timeout, pass;
  wb_entry_t first_exp, first_act;

  opimm_wb_checker_if bus ();

  opimm_wb_checker dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .match_count       (match_count),
    .unsupported_count (unsupported_count),
    .err_mismatch      (err_mismatch),
    .err_unexpected    (err_unexpected),
    .err_overflow      (err_overflow),
    .err_timeout       (err_timeout),
    .first_exp         (first_exp),
    .first_act         (first_act),
    .pass              (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  // Expected-state model maintained by hand in the driver
  logic [31:0] e_mc;
  logic [15:0] e_uc;
  logic [3:0]  e_err;
  wb_entry_t   e_fe, e_fa;

  task automatic check(input string tag, input status_t act, input status_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got mc=%0d uc=%0d err=%b pass=%b fe=%h fa=%h | want mc=%0d uc=%0d err=%b pass=%b fe=%h fa=%h",
               tag, cyc, act.mc, act.uc, act.err, act.pass, act.fe, act.fa,
               exp.mc, exp.uc, exp.err, exp.pass, exp.fe, exp.fa);
    end
  endtask

  // Monitor: compares every queued snapshot on the cycle it becomes due
  always @(negedge clk) begin
    status_t act;
    exp_t    e;
    act.mc   = match_count;
    act.uc   = unsupported_count;
    act.err  = {err_mismatch, err_unexpected, err_overflow, err_timeout};
    act.pass = pass;
    act.fe   = first_exp;
    act.fa   = first_act;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      if (e.at != cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: snapshot due at cyc %0d seen at cyc %0d", e.tag, e.at, cyc);
      end else begin
        check(e.tag, act, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Independent behavioural model of the core's OP-IMM ALU
  function automatic logic [31:0] core_exec(input logic [31:0] ins, input logic [31:0] a);
    logic [31:0] b, r;
    logic [4:0]  sh;
    b  = {{20{ins[31]}}, ins[31:20]};
    sh = ins[24:20];
    r  = 32'd0;
    case (ins[14:12])
      3'd0: r = a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = (a >> sh) | ((ins[30] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      3'd6: r = a | b;
      3'd7: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic expect_now(input string tag);
    exp_t e;
    e.tag     = tag;
    e.at      = cyc + 1;
    e.st.mc   = e_mc;
    e.st.uc   = e_uc;
    e.st.err  = e_err;
    e.st.pass = ~|e_err;
    e.st.fe   = e_fe;
    e.st.fa   = e_fa;
    sbq.push_back(e);
  endtask

  task automatic clear_model();
    e_mc = '0; e_uc = '0; e_err = '0; e_fe = '0; e_fa = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    bus.init_we     = 1'b0;
    bus.init_addr   = '0;
    bus.init_data   = '0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    bus.init_we = 1'b1; bus.init_addr = a; bus.init_data = d;
  endtask

  task automatic issue(input logic [31:0] ins);
    bus.instr_valid = 1'b1; bus.instr = ins;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic do_reset(input string tag);
    next(); reset = 1'b1; clear_model(); expect_now(tag);
    next(); reset = 1'b0;
  endtask

  vec_t        tbl[15];
  logic [31:0] core_rf[32];

  initial begin
    int          s, n_rand;
    logic        pend;
    logic [4:0]  prd, rd, rs1;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] pdata, ins, res, a;

    reset = 1'b1;
    bus.init_we = 1'b0; bus.init_addr = '0; bus.init_data = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    clear_model();

    next(); expect_now("reset_state");
    next(); reset = 1'b0;

    // addi x6,x5,-1 with x5=0x10
    next(); preload(5'd5, 32'h0000_0010);
    next(); issue(32'hFFF2_8313);
    next(); wb(5'd6, 32'h0000_000F); e_mc++; expect_now("addi_basic");

    // srai / srli on a negative source, pipelined
    next(); preload(5'd5, 32'h8000_0000);
    next(); issue(32'h4042_D393);
    next(); issue(32'h0042_D413); wb(5'd7, 32'hF800_0000); e_mc++; expect_now("srai");
    next(); wb(5'd8, 32'h0800_0000); e_mc++; expect_now("srli");

    // Remaining funct3 encodings and back-to-back dependencies, x5=0x80000000
    tbl[0]  = '{enc(12'h001, 5'd5, 3'd2, 5'd9),   5'd9,  32'h0000_0001};
    tbl[1]  = '{enc(12'h001, 5'd5, 3'd3, 5'd10),  5'd10, 32'h0000_0000};
    tbl[2]  = '{enc(12'hFFF, 5'd5, 3'd4, 5'd11),  5'd11, 32'h7FFF_FFFF};
    tbl[3]  = '{enc(12'h0F0, 5'd5, 3'd6, 5'd12),  5'd12, 32'h8000_00F0};
    tbl[4]  = '{enc(12'h800, 5'd5, 3'd7, 5'd13),  5'd13, 32'h8000_0000};
    tbl[5]  = '{enc(12'h001, 5'd5, 3'd1, 5'd14),  5'd14, 32'h0000_0000};
    tbl[6]  = '{enc(12'h005, 5'd0, 3'd0, 5'd15),  5'd15, 32'h0000_0005};
    tbl[7]  = '{enc(12'h003, 5'd15, 3'd0, 5'd15), 5'd15, 32'h0000_0008};
    tbl[8]  = '{enc(12'hFFF, 5'd15, 3'd2, 5'd16), 5'd16, 32'h0000_0000};
    tbl[9]  = '{enc(12'hFFF, 5'd15, 3'd3, 5'd17), 5'd17, 32'h0000_0001};
    tbl[10] = '{enc(12'h003, 5'd15, 3'd5, 5'd18), 5'd18, 32'h0000_0001};
    tbl[11] = '{enc(12'h41F, 5'd13, 3'd5, 5'd19), 5'd19, 32'hFFFF_FFFF};
    tbl[12] = '{enc(12'hFFF, 5'd5, 3'd0, 5'd20),  5'd20, 32'h7FFF_FFFF};
    tbl[13] = '{enc(12'h001, 5'd11, 3'd0, 5'd21), 5'd21, 32'h8000_0000};
    tbl[14] = '{enc(12'h7FF, 5'd0, 3'd0, 5'd22),  5'd22, 32'h0000_07FF};
    for (int i = 0; i < 15; i++) begin
      next(); issue(tbl[i].ins);
      if (i > 0) begin
        wb(tbl[i-1].rd, tbl[i-1].res); e_mc++; expect_now($sformatf("vec%0d", i - 1));
      end
    end
    next(); wb(tbl[14].rd, tbl[14].res); e_mc++; expect_now("vec14");

    // Non-OP-IMM instruction counts as unsupported and pushes nothing
    next(); issue(32'h00B5_0533); e_uc++; expect_now("unsupported");

    // rd==0 never pushes: no timeout after a long idle
    next(); issue(32'h0000_0013);
    next(); issue(enc(12'h005, 5'd5, 3'd0, 5'd0));
    repeat (70) next();
    expect_now("rd0_no_push");

    // Same-cycle preload and commit to x16: commit wins
    next(); issue(enc(12'h007, 5'd0, 3'd0, 5'd16)); preload(5'd16, 32'h0000_0099);
    next(); wb(5'd16, 32'h0000_0007); issue(enc(12'h000, 5'd16, 3'd0, 5'd17)); e_mc++;
    expect_now("commit_vs_preload");
    next(); wb(5'd17, 32'h0000_0007); e_mc++; expect_now("commit_wins");

    // Mismatch latches first_exp/first_act once
    next(); preload(5'd5, 32'h0000_0010);
    next(); issue(32'hFFF2_8313);
    next(); wb(5'd6, 32'h0000_0010);
    e_err[3] = 1'b1; e_fe = '{rd: 5'd6, data: 32'h0000_000F}; e_fa = '{rd: 5'd6, data: 32'h0000_0010};
    expect_now("mismatch");
    next(); issue(32'hFFF2_8313);
    next(); wb(5'd6, 32'h0000_0011); expect_now("mismatch_second");
    next(); issue(32'hFFF2_8313);
    next(); wb(5'd6, 32'h0000_000F); e_mc++; expect_now("match_after_mismatch");

    do_reset("reset_clears");

    // Overflow on the 9th push, timeout 64 cycles after the first push
    s = 0;
    for (int i = 0; i < 9; i++) begin
      next(); issue(enc(12'h001, 5'd0, 3'd0, 5'd1));
      if (i == 0) s = cyc;
      if (i == 7) expect_now("fifo_full_no_ovf");
      if (i == 8) begin e_err[1] = 1'b1; expect_now("overflow"); end
    end
    while (cyc < s + 63) next();
    expect_now("timeout_not_yet");
    next(); e_err[0] = 1'b1; expect_now("timeout");

    // Push and pop together while full keeps the new entry
    next(); issue(enc(12'h002, 5'd0, 3'd0, 5'd2)); wb(5'd1, 32'h1); e_mc++;
    expect_now("full_push_pop");
    for (int i = 0; i < 7; i++) begin next(); wb(5'd1, 32'h1); e_mc++; end
    next(); wb(5'd2, 32'h2); e_mc++; expect_now("full_push_kept");

    do_reset("reset_again");

    // Writeback into an empty queue, with a same-cycle push that must survive
    next(); issue(enc(12'h123, 5'd0, 3'd0, 5'd20)); wb(5'd3, 32'h0);
    e_err[2] = 1'b1; expect_now("unexpected");
    next(); wb(5'd20, 32'h0000_0123); e_mc++; expect_now("empty_push_kept");

    // Reset leaves the shadow regfile intact: x5 is still 0x10
    do_reset("reset_flags");
    next(); issue(32'h0002_8313);
    next(); wb(5'd6, 32'h0000_0010); e_mc++; expect_now("shadow_survives_reset");

    // Random OP-IMM stream against a behavioural core model
    do_reset("reset_random");
    void'($urandom(654));
    core_rf[0] = '0;
    for (int r = 1; r < 32; r++) begin
      next();
      core_rf[r] = $urandom;
      preload(5'(r), core_rf[r]);
    end
    pend = 1'b0; prd = '0; pdata = '0; n_rand = 0;
    for (int i = 0; i < 100; i++) begin
      next();
      if (pend) wb(prd, pdata);
      f3  = 3'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      imm = 12'($urandom);
      if (f3 == 3'd1) imm[11:5] = 7'b0;
      if (f3 == 3'd5) imm[11:5] = {1'b0, imm[10], 5'b0};
      ins = enc(imm, rs1, f3, rd);
      issue(ins);
      a   = (rs1 == 5'd0) ? 32'd0 : core_rf[rs1];
      res = core_exec(ins, a);
      pend = (rd != 5'd0);
      if (pend) begin
        core_rf[rd] = res; prd = rd; pdata = res; n_rand++;
      end
    end
    next(); if (pend) wb(prd, pdata);
    e_mc = 32'(n_rand); expect_now("random_stream");

    repeat (3) next();
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: snapshot due at cyc %0d never compared", e.tag, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/opimm_wb_checker.md
Name: opimm_wb_checker

Overview:
- Consumer-side counterpart to the core's instruction-stream driver.
- Watches the same OP-IMM (opcode 0010011) instruction stream fed into the core.
- Computes the expected architectural result from a shadow register file, queues the expected writebacks, and matches them in order against the core's register-writeback port.
- Flags mismatches, unexpected writebacks, queue overflow and timeouts; sits beside the core in the verification top.

Parameters:
- XLEN, 32, data word width.
- NUM_REGS, 32, architectural registers; x0 is hardwired to zero.
- FIFO_DEPTH, 8, expected-writeback queue entries (power of 2).
- TIMEOUT, 64, max cycles with a non-empty queue and no writeback before erroring.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init_we  in  1  shadow regfile preload strobe
- init_addr  in  5  preload register index
- init_data  in  XLEN  preload value
- instr_valid  in  1  instr is issued this cycle
- instr  in  32  instruction word
- wb_valid  in  1  core commits a register write this cycle
- wb_addr  in  5  committed rd
- wb_data  in  XLEN  committed value
- match_count  out  32  writebacks matched
- unsupported_count  out  16  issued non-OP-IMM instructions
- err_mismatch  out  1  sticky
- err_unexpected  out  1  sticky
- err_overflow  out  1  sticky
- err_timeout  out  1  sticky
- first_exp  out  5+XLEN  {rd,data} expected at the first mismatch
- first_act  out  5+XLEN  {rd,data} observed at the first mismatch
- pass  out  1  no error flag is set

Behaviour:
- Reset (clk edge with reset=1):
  - Clears the FIFO, counters, error flags, first_exp/first_act and the timeout counter.
  - The shadow regfile is NOT cleared; it mirrors the core regfile, which is not reset.
  - pass=1 during and after reset until an error occurs.
- Preload: init_we writes shadow[init_addr] at the clock edge. Writes to addr 0 are ignored. Preload is legal during reset.
- Decode (instr_valid, opcode==0010011):
  - Fields: rd=[11:7], funct3=[14:12], rs1=[19:15], imm=sign-extended [31:20], shamt=[24:20].
  - Source operand: src=shadow[rs1], or 0 when rs1==0.
- Result by funct3:
  - 000 ADDI: src+imm, mod 2^XLEN.
  - 010 SLTI: signed src<imm -> 1/0.
  - 011 SLTIU: unsigned src<imm -> 1/0.
  - 100 XORI: src^imm.
  - 110 ORI: src|imm.
  - 111 ANDI: src&imm.
  - 001 SLLI: src<<shamt.
  - 101: SRAI if instr[30]=1, else SRLI, shift amount shamt.
- Commit to shadow:
  - If rd!=0: shadow[rd]<=result and push {rd,result} into the FIFO, both at the same edge.
  - If rd==0: nothing is pushed (covers the reset NOP 0x00000013).
  - Back-to-back dependent instructions see the updated shadow value the next cycle (one instruction per cycle max).
- Non-OP-IMM with instr_valid: unsupported_count+1, saturating at 0xFFFF. No push.
- Same-cycle instr commit and init_we to the same register: the instr commit wins.
- Writeback matching:
  - Only wb_valid with wb_addr!=0 is considered.
  - Queue empty -> err_unexpected set.
  - Otherwise pop the head. If {wb_addr,wb_data}==head, match_count+1. Else set err_mismatch; on the first mismatch only, latch first_exp=head and first_act={wb_addr,wb_data}.
- FIFO boundaries:
  - Push and pop in the same cycle are always legal, including when full (count unchanged) and when empty (the pop sees the pre-push empty state, so err_unexpected is set and the pushed entry is kept).
  - Push while full without a pop: the entry is dropped and err_overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Timeout:
  - The counter increments each cycle the queue is non-empty and no pop occurs.
  - It clears on a pop or when the queue is empty.
  - When it reaches TIMEOUT, err_timeout is set and the counter holds.
- Error flags are sticky until reset. pass = ~(any err flag), registered.
- Latency: every flag and counter updates at the clock edge following the causing input cycle.

Decomposition:
- Shared package opimm_pkg holds:
  - OPC_OPIMM=7'b0010011.
  - The funct3 encodings F3_ADDI..F3_SRXI.
  - The wb_entry_t struct {logic[4:0] rd; logic[XLEN-1:0] data;}.
  - The function opimm_exec(funct3, instr30, src, imm) -> result.
- Sub-module: sync_fifo (parameterised width/depth; push, pop, full, empty, head). Reusable for other queues.

Test Plan:
- Preload x5=0x00000010; issue addi x6,x5,-1 (0xFFF28313); wb (6,0x0000000F) next cycle -> match_count=1, pass=1.
- Preload x5=0x80000000; issue srai x7,x5,4 (0x4042D393); wb (7,0xF8000000) -> match. Then srli x8,x5,4; wb (8,0x08000000) -> match_count=2.
- Preload x5=0x10; addi x6,x5,-1; wb (6,0x00000010) -> err_mismatch=1, first_exp={6,0x0000000F}, first_act={6,0x00000010}, pass=0.
- 9 consecutive addi x1,x0,1 with no wb (FIFO_DEPTH=8, TIMEOUT=64) -> err_overflow=1 on the 9th; err_timeout=1 64 cycles after the first push.
- wb (3,0x0) with an empty queue -> err_unexpected=1. Then assert reset for 1 cycle -> all flags 0, match_count=0, pass=1; shadow x5 still 0x10 (verified by a follow-up addi x6,x5,0 matching wb (6,0x10)).
- 100 cycles of random OP-IMM (seed 654) with a randomised preload mirrored into the core; the checker is connected to the core's wb port -> match_count equals the number of rd!=0 issues and pass=1.
